// File: rtl/shot_clock_pkg.sv
// Shot-clock controller shared types and constants.
// Imported by the interface, the debouncer user and the top.
package shot_clock_pkg;

  localparam int SEC_W = 5;
  localparam int DEF_FULL_SEC = 24;
  localparam int DEF_SHORT_SEC = 14;

  typedef logic [SEC_W-1:0] sec_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

endpackage

// File: rtl/shot_clock_ctrl_if.sv
// Button inputs and display/status outputs of the shot clock.
// SHOT_WARN_EN adds the warn blink output.
interface shot_clock_ctrl_if;
  import shot_clock_pkg::*;

  logic btn_start;
  logic btn_full;
  logic btn_short;
  sec_t sec;
  logic tick;
  logic running;
  logic expired;
  logic buzzer;
`ifdef SHOT_WARN_EN
  logic warn;

  modport master (
    output btn_start, btn_full, btn_short,
    input  sec, tick, running, expired, buzzer, warn
  );

  modport slave (
    input  btn_start, btn_full, btn_short,
    output sec, tick, running, expired, buzzer, warn
  );
`else
  modport master (
    output btn_start, btn_full, btn_short,
    input  sec, tick, running, expired, buzzer
  );

  modport slave (
    input  btn_start, btn_full, btn_short,
    output sec, tick, running, expired, buzzer
  );
`endif

endinterface

// File: rtl/btn_debounce.sv
// Raw push-button to one-cycle press pulse:
// 2-flop sync, stability filter, rising-edge detect.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_END =
    CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          lvl;
  logic          armed;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [CW-1:0] qcnt;

  assign accept = (sync[1] != lvl) &&
                  (cnt == CNT_END);
  assign pulse  = accept && sync[1] && armed;

  // new level accepted after DEB_CYCLES stable cycles;
  // a button held through reset must be seen released
  // (quiet for DEB_CYCLES) before any press counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      lvl   <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      qcnt  <= '0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (accept) begin
        lvl <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (!armed) begin
        if (sync != 2'b00) begin
          qcnt <= '0;
        end else if (qcnt == CNT_END) begin
          armed <= 1'b1;
        end else begin
          qcnt <= qcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencer: buttons, run/pause/reload FSM,
// 1 s tick, expiry buzzer. SHOT_WARN_EN adds warn blink.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int FULL_SEC   = DEF_FULL_SEC,
  parameter int SHORT_SEC  = DEF_SHORT_SEC,
  parameter int ALARM_SEC  = 2
) (
  input logic             clk,
  input logic             rst,
  shot_clock_ctrl_if.slave bus
);

  localparam int PW =
    (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] P_END =
    PW'(CLK_FREQ - 1);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [AW-1:0] A_END =
    AW'(ALARM_SEC);

  state_t        state;
  sec_t          sec_q;
  sec_t          rval;
  logic [PW-1:0] presc;
  logic [AW-1:0] alarm;
  logic          tick_q;
  logic          running_q;
  logic          expired_q;
  logic          buzzer_q;
  logic          p_start;
  logic          p_full;
  logic          p_short;
  logic          reload;
  logic          go;
  logic          wrap;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk(clk), .rst(rst),
    .btn(bus.btn_start), .pulse(p_start)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_full (
    .clk(clk), .rst(rst),
    .btn(bus.btn_full), .pulse(p_full)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_short (
    .clk(clk), .rst(rst),
    .btn(bus.btn_short), .pulse(p_short)
  );

  // full beats short beats start
  assign reload = p_full | p_short;
  assign go     = p_start & ~reload;
  assign rval   = p_full ? SEC_W'(FULL_SEC)
                         : SEC_W'(SHORT_SEC);
  assign wrap   = (presc == P_END);

  assign bus.sec     = sec_q;
  assign bus.tick    = tick_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.buzzer  = buzzer_q;

  // run/pause/reload sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sec_q     <= SEC_W'(FULL_SEC);
      presc     <= '0;
      alarm     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (reload) begin
            sec_q <= rval;
          end else if (go) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (reload) begin
            sec_q <= rval;
            presc <= '0;
          end else if (go) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end else if (wrap) begin
            presc  <= '0;
            tick_q <= 1'b1;
            sec_q  <= sec_q - 1'b1;
            if (sec_q == SEC_W'(1)) begin
              state     <= EXPIRED;
              running_q <= 1'b0;
              expired_q <= 1'b1;
              buzzer_q  <= 1'b1;
              alarm     <= '0;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        PAUSE: begin
          if (reload) begin
            sec_q <= rval;
            presc <= '0;
          end else if (go) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        EXPIRED: begin
          if (reload) begin
            state     <= PAUSE;
            sec_q     <= rval;
            presc     <= '0;
            expired_q <= 1'b0;
            buzzer_q  <= 1'b0;
          end else if (wrap) begin
            presc <= '0;
            if (buzzer_q) begin
              alarm <= alarm + 1'b1;
              if (alarm + 1'b1 == A_END)
                buzzer_q <= 1'b0;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
      endcase
    end
  end

  // a decrement only ever happens from a nonzero value
  assert property (@(posedge clk) disable iff (rst)
    (state == RUN && wrap && !reload && !go)
      |-> (sec_q != '0));

`ifdef SHOT_WARN_EN
  localparam int BL =
    (CLK_FREQ / 4 > 0) ? CLK_FREQ / 4 : 1;
  localparam int BW = $clog2(BL + 1);
  localparam logic [BW-1:0] B_END = BW'(BL - 1);

  logic [BW-1:0] blink;
  logic          warn_q;

  assign bus.warn = warn_q;

  // 2 Hz blink in the last five seconds of a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink  <= '0;
      warn_q <= 1'b0;
    end else if (state != RUN ||
                 sec_q > SEC_W'(5)) begin
      blink  <= '0;
      warn_q <= 1'b0;
    end else if (blink == B_END) begin
      blink  <= '0;
      warn_q <= ~warn_q;
    end else begin
      blink <= blink + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Self-checking bench for shot_clock_ctrl.
// Tick scoreboard: expected gap/sec queued, popped per tick.
module tb_shot_clock_ctrl;
  import shot_clock_pkg::*;

  localparam int CLK_FREQ = 10;
  localparam int DEB = 3;
  // edges from driving a button to the FSM acting on it
  localparam int LAT = 2 + DEB;

  typedef struct {
    int   gap;
    sec_t sec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  exp_t sb[$];

  shot_clock_ctrl_if bus();

  shot_clock_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .DEB_CYCLES(DEB),
    .FULL_SEC(24),
    .SHORT_SEC(14),
    .ALARM_SEC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget,
                           output int waited);
    waited = 0;
    while (waited < budget) begin
      @(posedge clk);
      #1;
      waited++;
      if (bus.tick === 1'b1) return;
    end
    waited = -1;
  endtask

  task automatic push_ticks(input int first_gap,
                            input int from,
                            input int to);
    exp_t e;
    for (int i = from; i >= to; i--) begin
      e.gap = (i == from) ? first_gap : CLK_FREQ;
      e.sec = SEC_W'(i);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    bus.btn_start = 1'b0;
    bus.btn_full  = 1'b0;
    bus.btn_short = 1'b0;
    #2 rst = 1'b1;
    clk_n(2);
    n_run++;
    if (bus.sec !== 5'd24) begin
      n_fail++;
      $display("FAIL reset_sec got %0d want 24",
               bus.sec);
    end
    n_run++;
    if ({bus.tick, bus.running, bus.expired,
         bus.buzzer} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.tick, bus.running,
                bus.expired, bus.buzzer});
    end
    rst = 1'b0;
    clk_n(8);
    n_run++;
    if (bus.running !== 1'b0 || bus.sec !== 5'd24) begin
      n_fail++;
      $display("FAIL idle_hold got run=%b sec=%0d want 0/24",
               bus.running, bus.sec);
    end
  endtask

  task automatic test_countdown();
    int   w;
    exp_t e;
    bus.btn_start = 1'b1;
    clk_n(LAT - 1);
    n_run++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL start_early got %b want 0",
               bus.running);
    end
    clk_n(1);
    n_run++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_run got %b want 1",
               bus.running);
    end
    bus.btn_start = 1'b0;
    push_ticks(CLK_FREQ, 23, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(e.gap + 3, w);
      n_run++;
      if (w !== e.gap || bus.sec !== e.sec) begin
        n_fail++;
        $display("FAIL count_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
                 w, bus.sec, e.gap, e.sec);
      end
    end
  endtask

  task automatic test_expiry();
    int   w;
    int   k;
    int   ticks;
    exp_t e;
    push_ticks(CLK_FREQ, 0, 0);
    e = sb.pop_front();
    wait_tick(e.gap + 3, w);
    n_run++;
    if (w !== e.gap || bus.sec !== e.sec) begin
      n_fail++;
      $display("FAIL last_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
               w, bus.sec, e.gap, e.sec);
    end
    n_run++;
    if ({bus.running, bus.expired, bus.buzzer}
        !== 3'b011) begin
      n_fail++;
      $display("FAIL expire_flags got %b want 011",
               {bus.running, bus.expired, bus.buzzer});
    end
    k = 0;
    ticks = 0;
    while (bus.buzzer === 1'b1 && k < 30) begin
      clk_n(1);
      k++;
      if (bus.tick === 1'b1) ticks++;
    end
    n_run++;
    if (k !== 20 || ticks !== 0) begin
      n_fail++;
      $display("FAIL buzzer_len got %0d cyc %0d ticks want 20 cyc 0 ticks",
               k, ticks);
    end
    bus.btn_start = 1'b1;
    clk_n(LAT);
    bus.btn_start = 1'b0;
    clk_n(5);
    n_run++;
    if ({bus.running, bus.expired, bus.buzzer}
        !== 3'b010 || bus.sec !== 5'd0) begin
      n_fail++;
      $display("FAIL start_ignored got %b sec=%0d want 010 sec=0",
               {bus.running, bus.expired, bus.buzzer},
               bus.sec);
    end
    bus.btn_full = 1'b1;
    clk_n(LAT);
    bus.btn_full = 1'b0;
    n_run++;
    if (bus.sec !== 5'd24 || {bus.running,
        bus.expired, bus.buzzer} !== 3'b000) begin
      n_fail++;
      $display("FAIL expired_reload got %b sec=%0d want 000 sec=24",
               {bus.running, bus.expired, bus.buzzer},
               bus.sec);
    end
    clk_n(5);
    bus.btn_start = 1'b1;
    clk_n(LAT);
    bus.btn_start = 1'b0;
    n_run++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL restart got %b want 1",
               bus.running);
    end
  endtask

  task automatic test_pause();
    int   w;
    int   ticks;
    exp_t e;
    push_ticks(CLK_FREQ, 23, 23);
    e = sb.pop_front();
    wait_tick(e.gap + 3, w);
    n_run++;
    if (w !== e.gap || bus.sec !== e.sec) begin
      n_fail++;
      $display("FAIL pre_pause got gap=%0d sec=%0d want gap=%0d sec=%0d",
               w, bus.sec, e.gap, e.sec);
    end
    clk_n(2);
    bus.btn_start = 1'b1;
    clk_n(LAT);
    bus.btn_start = 1'b0;
    n_run++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause got %b want 0",
               bus.running);
    end
    ticks = 0;
    repeat (50) begin
      clk_n(1);
      if (bus.tick === 1'b1) ticks++;
    end
    n_run++;
    if (ticks !== 0 || bus.sec !== 5'd23) begin
      n_fail++;
      $display("FAIL pause_hold got %0d ticks sec=%0d want 0 ticks sec=23",
               ticks, bus.sec);
    end
    bus.btn_start = 1'b1;
    clk_n(LAT);
    bus.btn_start = 1'b0;
    n_run++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume got %b want 1",
               bus.running);
    end
    push_ticks(4, 22, 22);
    e = sb.pop_front();
    wait_tick(e.gap + 3, w);
    n_run++;
    if (w !== e.gap || bus.sec !== e.sec) begin
      n_fail++;
      $display("FAIL resume_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
               w, bus.sec, e.gap, e.sec);
    end
  endtask

  task automatic test_reload();
    int   w;
    exp_t e;
    push_ticks(CLK_FREQ, 21, 9);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(e.gap + 3, w);
      n_run++;
      if (w !== e.gap || bus.sec !== e.sec) begin
        n_fail++;
        $display("FAIL run_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
                 w, bus.sec, e.gap, e.sec);
      end
    end
    clk_n(2);
    bus.btn_short = 1'b1;
    clk_n(LAT);
    bus.btn_short = 1'b0;
    n_run++;
    if (bus.sec !== 5'd14 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL short_reload got sec=%0d run=%b want 14/1",
               bus.sec, bus.running);
    end
    push_ticks(CLK_FREQ, 13, 13);
    e = sb.pop_front();
    wait_tick(e.gap + 3, w);
    n_run++;
    if (w !== e.gap || bus.sec !== e.sec) begin
      n_fail++;
      $display("FAIL short_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
               w, bus.sec, e.gap, e.sec);
    end
    bus.btn_full  = 1'b1;
    bus.btn_short = 1'b1;
    clk_n(LAT);
    bus.btn_full  = 1'b0;
    bus.btn_short = 1'b0;
    n_run++;
    if (bus.sec !== 5'd24 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL full_wins got sec=%0d run=%b want 24/1",
               bus.sec, bus.running);
    end
    push_ticks(CLK_FREQ, 23, 23);
    e = sb.pop_front();
    wait_tick(e.gap + 3, w);
    n_run++;
    if (w !== e.gap || bus.sec !== e.sec) begin
      n_fail++;
      $display("FAIL full_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
               w, bus.sec, e.gap, e.sec);
    end
    clk_n(5);
    bus.btn_short = 1'b1;
    clk_n(LAT);
    bus.btn_short = 1'b0;
    n_run++;
    if (bus.tick !== 1'b0 || bus.sec !== 5'd14) begin
      n_fail++;
      $display("FAIL reload_on_wrap got tick=%b sec=%0d want 0/14",
               bus.tick, bus.sec);
    end
    push_ticks(CLK_FREQ, 13, 13);
    e = sb.pop_front();
    wait_tick(e.gap + 3, w);
    n_run++;
    if (w !== e.gap || bus.sec !== e.sec) begin
      n_fail++;
      $display("FAIL wrap_reload_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
               w, bus.sec, e.gap, e.sec);
    end
  endtask

  task automatic test_bounce();
    bus.btn_start = 1'b1;
    clk_n(1);
    bus.btn_start = 1'b0;
    clk_n(4);
    bus.btn_start = 1'b1;
    clk_n(2);
    bus.btn_start = 1'b0;
    clk_n(6);
    n_run++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch got run=%b want 1",
               bus.running);
    end
    bus.btn_start = 1'b1;
    clk_n(3);
    bus.btn_start = 1'b0;
    clk_n(LAT - 3);
    n_run++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_press got run=%b want 0",
               bus.running);
    end
    clk_n(20);
    n_run++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL single_toggle got run=%b want 0",
               bus.running);
    end
  endtask

  task automatic test_reset_mid();
    int   w;
    exp_t e;
    bus.btn_short = 1'b1;
    clk_n(LAT);
    bus.btn_short = 1'b0;
    n_run++;
    if (bus.sec !== 5'd14 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_reload got sec=%0d run=%b want 14/0",
               bus.sec, bus.running);
    end
    clk_n(5);
    bus.btn_start = 1'b1;
    clk_n(LAT);
    bus.btn_start = 1'b0;
    push_ticks(CLK_FREQ, 13, 7);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(e.gap + 3, w);
      n_run++;
      if (w !== e.gap || bus.sec !== e.sec) begin
        n_fail++;
        $display("FAIL pre_reset_tick got gap=%0d sec=%0d want gap=%0d sec=%0d",
                 w, bus.sec, e.gap, e.sec);
      end
    end
    clk_n(3);
    rst = 1'b1;
    #1;
    n_run++;
    if (bus.sec !== 5'd24 || {bus.tick, bus.running,
        bus.expired, bus.buzzer} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset got sec=%0d flags=%b want 24/0000",
               bus.sec, {bus.tick, bus.running,
                         bus.expired, bus.buzzer});
    end
    bus.btn_start = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(20);
    n_run++;
    if (bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL held_thru_reset got run=%b want 0",
               bus.running);
    end
    bus.btn_start = 1'b0;
    clk_n(10);
    bus.btn_start = 1'b1;
    clk_n(LAT);
    bus.btn_start = 1'b0;
    n_run++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL repress got run=%b want 1",
               bus.running);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_expiry();
    test_pause();
    test_reload();
    test_bounce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
